// File: rtl/dff8_bank_pkg.sv
// Shared constants, lock-state encoding and the round-robin search helper
// for the dff8 bank arbiter.
package dff8_bank_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Returns the first requester at or after ptr (mod num) with req set, or -1.
    function automatic int rr_next(input int ptr, input logic [31:0] req_vec, input int num);
        int         idx;
        logic [4:0] c;
        logic       hit;
        idx = -1;
        for (int k = 0; k < 32; k++) begin
            c   = 5'((ptr + k) % num);
            hit = (k < num) && (idx < 0) && req_vec[c];
            idx = hit ? int'(c) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dff8_bank_bank.sv
// DEPTH x DATA_W register storage: one write port, one combinational read port.
// Addresses outside 0..DEPTH-1 never match, so writes drop and reads give zero.
module dff8_bank
    import dff8_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next contents: only the addressed entry takes the write data.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            mem_d[j] = (we && (waddr == ADDR_W'(j))) ? wdata : mem_q[j];
        end
    end

    // Read mux built as an AND-OR tree over all entries.
    always_comb begin
        rdata = {DATA_W{1'b0}};
        for (int j = 0; j < DEPTH; j++) begin
            rdata = rdata | ({DATA_W{raddr == ADDR_W'(j)}} & mem_q[j]);
        end
    end

    // Storage flops with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= {DATA_W{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/dff8_bank_arbiter.sv
// Round-robin arbiter granting one requester per cycle a single access to a
// shared register bank, with a bounded lock for back-to-back grants.
module dff8_bank_arbiter
    import dff8_bank_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int LOCK_MAX = 3,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(LOCK_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    output logic [ID_W-1:0]           rd_id,
    output logic [CNT_W-1:0]          lock_cnt
);

    lock_state_e       lock_st_q, lock_st_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [ID_W-1:0]   rd_id_q, rd_id_d;

    int                rr_idx_s;
    logic              hold_s;
    logic              xfer_s;
    logic [NUM_REQ-1:0] gnt_rr_s, gnt_own_s, gnt_s;
    logic [ID_W-1:0]   win_idx_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              win_we_s, win_lock_s;
    logic [DATA_W-1:0] bank_rdata_s;

    // Grant selection and winner-side operand mux.
    always_comb begin
        hold_s   = (lock_st_q == LOCKED) && req[owner_q] && (lock_cnt_q < CNT_W'(LOCK_MAX));
        rr_idx_s = rr_next(int'(rr_ptr_q), 32'(req), NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_rr_s[i]  = (rr_idx_s == i);
            gnt_own_s[i] = (owner_q == ID_W'(i));
        end
        if (!rst_n) begin
            gnt_s = {NUM_REQ{1'b0}};
        end else if (hold_s) begin
            gnt_s = gnt_own_s;
        end else begin
            gnt_s = gnt_rr_s;
        end
        xfer_s      = |gnt_s;
        win_idx_s   = {ID_W{1'b0}};
        win_addr_s  = {ADDR_W{1'b0}};
        win_wdata_s = {DATA_W{1'b0}};
        win_we_s    = 1'b0;
        win_lock_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_idx_s   = win_idx_s   | ({ID_W{gnt_s[i]}} & ID_W'(i));
            win_addr_s  = win_addr_s  | ({ADDR_W{gnt_s[i]}} & addr[i*ADDR_W +: ADDR_W]);
            win_wdata_s = win_wdata_s | ({DATA_W{gnt_s[i]}} & wdata[i*DATA_W +: DATA_W]);
            win_we_s    = win_we_s    | (gnt_s[i] & we[i]);
            win_lock_s  = win_lock_s  | (gnt_s[i] & lock[i]);
        end
    end

    // Lock FSM, pointer rotation and read-return next state.
    always_comb begin
        lock_st_d  = lock_st_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (xfer_s) begin
            rr_ptr_d = (win_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (win_idx_s + ID_W'(1));
            if (win_lock_s) begin
                if ((lock_st_q == LOCKED) && (owner_q == win_idx_s) &&
                    (lock_cnt_q < CNT_W'(LOCK_MAX))) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end else begin
                    // Fresh lock, or the owner re-arming after exhausting its budget.
                    lock_st_d  = LOCKED;
                    owner_d    = win_idx_s;
                    lock_cnt_d = CNT_W'(1);
                end
            end else begin
                lock_st_d  = UNLOCKED;
                lock_cnt_d = {CNT_W{1'b0}};
            end
        end else if ((lock_st_q == LOCKED) && !req[owner_q]) begin
            lock_st_d  = UNLOCKED;
            lock_cnt_d = {CNT_W{1'b0}};
        end else begin
            lock_st_d = lock_st_q;
        end
        rvalid_d = xfer_s && !win_we_s;
        rdata_d  = rvalid_d ? bank_rdata_s : rdata_q;
        rd_id_d  = rvalid_d ? win_idx_s : rd_id_q;
    end

    // Arbiter state and registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_st_q  <= UNLOCKED;
            owner_q    <= {ID_W{1'b0}};
            lock_cnt_q <= {CNT_W{1'b0}};
            rr_ptr_q   <= {ID_W{1'b0}};
            rdata_q    <= {DATA_W{1'b0}};
            rvalid_q   <= 1'b0;
            rd_id_q    <= {ID_W{1'b0}};
        end else begin
            lock_st_q  <= lock_st_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    dff8_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (xfer_s & win_we_s),
        .waddr (win_addr_s),
        .wdata (win_wdata_s),
        .raddr (win_addr_s),
        .rdata (bank_rdata_s)
    );

    assign gnt      = gnt_s;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign rd_id    = rd_id_q;
    assign lock_cnt = lock_cnt_q;

endmodule

// File: tb/tb_dff8_bank_arbiter.sv
// Directed bench for dff8_bank_arbiter: a behavioural model checked every
// negative edge, plus hand-computed literal expectations along the way.
module tb_dff8_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, we, lock;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [1:0]  rd_id;
    logic [1:0]  lock_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    // Model state: plain integers following the arbitration rules.
    int   mbank [4];
    int   mptr, mowner, mcnt, m_rdata, m_rdid;
    bit   mlocked, m_rvalid;
    int   w, a;
    logic [3:0] eg;

    dff8_bank_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .lock     (lock),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rd_id    (rd_id),
        .lock_cnt (lock_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int model_winner();
        if (mlocked && req[mowner] && mcnt < 3) return mowner;
        for (int k = 0; k < 4; k++) begin
            if (req[(mptr + k) % 4]) return (mptr + k) % 4;
        end
        return -1;
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) mbank[j] = 0;
            mptr = 0; mowner = 0; mcnt = 0; mlocked = 0;
            m_rvalid = 0; m_rdata = 0; m_rdid = 0;
            chk("rst_gnt", gnt, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_rdata", rdata, 0);
        end else begin
            chk("rvalid", rvalid, m_rvalid);
            chk("rdata", rdata, m_rdata);
            chk("rd_id", rd_id, m_rdid);
            chk("lock_cnt", lock_cnt, mcnt);
            w  = model_winner();
            eg = (w < 0) ? 4'b0000 : (4'b0001 << w);
            chk("gnt", gnt, eg);
            m_rvalid = 0;
            if (w >= 0) begin
                a = addr[w*2 +: 2];
                if (we[w]) mbank[a] = wdata[w*8 +: 8];
                else begin
                    m_rvalid = 1; m_rdata = mbank[a]; m_rdid = w;
                end
                mptr = (w + 1) % 4;
                if (lock[w]) begin
                    if (mlocked && w == mowner && mcnt < 3) mcnt++;
                    else begin mlocked = 1; mowner = w; mcnt = 1; end
                end else begin
                    mlocked = 0; mcnt = 0;
                end
            end else if (mlocked && !req[mowner]) begin
                mlocked = 0; mcnt = 0;
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [3:0] wr, input logic [3:0] lk,
                         input logic [7:0] ad, input logic [31:0] wd);
        req = r; we = wr; lock = lk; addr = ad; wdata = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0);
        #2 chk("gnt_in_reset", gnt, 4'b0000);
        tick(); tick();
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("idle_gnt", gnt, 4'b0000);
        chk("idle_rvalid", rvalid, 1'b0);
        chk("idle_rdata", rdata, 8'h00);

        // Every address reads back zero after reset.
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001, 4'b0000, 4'b0000, 8'(i), 32'h0);
            tick();
            chk("init_read_valid", rvalid, 1'b1);
            chk("init_read_data", rdata, 8'h00);
        end

        drive(4'b0001, 4'b0001, 4'b0000, 8'h02, 32'h0000_00A5);
        #1 chk("wr_gnt", gnt, 4'b0001);
        tick();
        drive(4'b0001, 4'b0000, 4'b0000, 8'h02, 32'h0);
        tick();
        chk("rd_valid", rvalid, 1'b1);
        chk("rd_data", rdata, 8'hA5);
        chk("rd_id", rd_id, 2'd0);
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0);
        tick();
        chk("rvalid_pulse", rvalid, 1'b0);

        // Requester 3 takes one grant so the pointer wraps back to 0.
        drive(4'b1000, 4'b0000, 4'b0000, 8'h00, 32'h0);
        tick();
        drive(4'b1111, 4'b0000, 4'b0000, 8'hE4, 32'h0);
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_gnt", gnt, 4'b0001 << (k % 4));
            tick();
            chk("rr_rd_id", rd_id, k % 4);
        end
        chk("rr_rdata_last", rdata, 8'h00);

        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0);
        tick();
        drive(4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0);
        tick();
        drive(4'b0011, 4'b0000, 4'b0010, 8'h00, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1 chk("lock_gnt", gnt, (k < 3) ? 4'b0010 : 4'b0001);
            tick();
            chk("lock_cnt_seq", lock_cnt, (k < 3) ? k + 1 : 0);
        end
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0);
        tick();

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(4'b0011, 4'b0011, 4'b0000, 8'h00, 32'h0000_2211);
        #1 chk("cont_gnt0", gnt, 4'b0001);
        tick();
        drive(4'b0010, 4'b0010, 4'b0000, 8'h00, 32'h0000_2211);
        #1 chk("cont_gnt1", gnt, 4'b0010);
        tick();
        drive(4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0);
        tick();
        chk("cont_valid", rvalid, 1'b1);
        chk("cont_data", rdata, 8'h22);

        drive(4'b0001, 4'b0001, 4'b0000, 8'h03, 32'h0000_00FF);
        tick();
        drive(4'b0001, 4'b0000, 4'b0000, 8'h03, 32'h0);
        @(posedge clk);
        #1 chk("pre_rst_valid", rvalid, 1'b1);
        chk("pre_rst_data", rdata, 8'hFF);
        #1 rst_n = 1'b0;
        #1 chk("async_rvalid", rvalid, 1'b0);
        chk("async_rdata", rdata, 8'h00);
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        drive(4'b0001, 4'b0000, 4'b0000, 8'h03, 32'h0);
        tick();
        chk("post_rst_valid", rvalid, 1'b1);
        chk("post_rst_data", rdata, 8'h00);
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
